// File: rtl/pmtk_tx_pkg.sv
// Shared definitions for the PMTK command transmitter: framing states,
// fixed sentence characters and checksum nibble encoding.
package pmtk_tx_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DOLLAR,
        PAYLOAD,
        STAR,
        CK_HI,
        CK_LO,
        CR,
        LF,
        FINISH
    } state_t;

    localparam logic [7:0] CHAR_DOLLAR = 8'h24;
    localparam logic [7:0] CHAR_STAR   = 8'h2A;
    localparam logic [7:0] CHAR_CR     = 8'h0D;
    localparam logic [7:0] CHAR_LF     = 8'h0A;

    // Uppercase ASCII hex digit for one checksum nibble.
    function automatic logic [7:0] nibble_to_hex(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART character serializer. A new character may be loaded in the last
// cycle of the previous stop bit, so characters can run back-to-back.
module uart_tx_byte #(
    parameter int BIT_TICKS = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx,
    output logic       char_done
);

    localparam int CNT_W = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(BIT_TICKS - 1);

    logic [CNT_W-1:0] baud_cnt_reg;
    logic [3:0]       bit_cnt_reg;
    logic [9:0]       frame_reg;
    logic             active_reg;
    logic             bit_end;
    logic             frame_end;

    assign bit_end   = (baud_cnt_reg == LAST_TICK);
    assign frame_end = active_reg && bit_end && (bit_cnt_reg == 4'd9);
    assign ready     = !active_reg || frame_end;
    assign char_done = frame_end;
    // Line is the frame LSB straight from a flop; the all-ones reset value is mark.
    assign tx        = frame_reg[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            frame_reg    <= '1;
            active_reg   <= 1'b0;
        end else if (load && ready) begin
            frame_reg    <= {1'b1, data, 1'b0};
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            active_reg   <= 1'b1;
        end else if (active_reg) begin
            if (bit_end) begin
                baud_cnt_reg <= '0;
                frame_reg    <= {1'b1, frame_reg[9:1]};
                if (bit_cnt_reg == 4'd9) begin
                    active_reg  <= 1'b0;
                    bit_cnt_reg <= '0;
                end else begin
                    bit_cnt_reg <= bit_cnt_reg + 4'd1;
                end
            end else begin
                baud_cnt_reg <= baud_cnt_reg + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pmtk_cmd_tx.sv
// PMTK command sentence transmitter: wraps a streamed payload as
// "$<payload>*<XOR checksum hex>\r\n" and sends it over a UART line.
module pmtk_cmd_tx
    import pmtk_tx_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD_RATE   = 9600,
    parameter int MAX_PAYLOAD = 80
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] pl_data,
    input  logic       pl_valid,
    input  logic       pl_last,
    output logic       pl_ready,
    output logic       gps_tx,
    output logic       busy,
    output logic       done,
    output logic       overlong
);

    localparam int BIT_TICKS = CLK_FREQ_HZ / BAUD_RATE;
    localparam int PL_W      = $clog2(MAX_PAYLOAD + 1);
    localparam logic [PL_W-1:0] PL_LAST_IDX = PL_W'(MAX_PAYLOAD - 1);

    logic [1:0]      rst_sync_reg;
    logic            rst_core_n;
    state_t          state_reg, state_next;
    logic [7:0]      checksum_reg, checksum_next;
    logic [PL_W-1:0] pl_cnt_reg, pl_cnt_next;
    logic            lf_loaded_reg, lf_loaded_next;
    logic            overlong_reg, overlong_next;
    logic            ser_load;
    logic [7:0]      ser_data;
    logic            ser_ready;
    logic            ser_done;

    // Assertion reaches the core at once; release is re-timed to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end
    assign rst_core_n = rst_sync_reg[1];

    uart_tx_byte #(
        .BIT_TICKS (BIT_TICKS)
    ) u_ser (
        .clk       (clk),
        .rst_n     (rst_core_n),
        .load      (ser_load),
        .data      (ser_data),
        .ready     (ser_ready),
        .tx        (gps_tx),
        .char_done (ser_done)
    );

    always_ff @(posedge clk or negedge rst_core_n) begin
        if (!rst_core_n) begin
            state_reg     <= IDLE;
            checksum_reg  <= '0;
            pl_cnt_reg    <= '0;
            lf_loaded_reg <= 1'b0;
            overlong_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            checksum_reg  <= checksum_next;
            pl_cnt_reg    <= pl_cnt_next;
            lf_loaded_reg <= lf_loaded_next;
            overlong_reg  <= overlong_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        checksum_next  = checksum_reg;
        pl_cnt_next    = pl_cnt_reg;
        lf_loaded_next = lf_loaded_reg;
        overlong_next  = 1'b0;
        ser_load       = 1'b0;
        ser_data       = CHAR_DOLLAR;
        pl_ready       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pl_valid) begin
                    state_next     = DOLLAR;
                    checksum_next  = '0;
                    pl_cnt_next    = '0;
                    lf_loaded_next = 1'b0;
                end
            end
            DOLLAR: begin
                ser_data = CHAR_DOLLAR;
                ser_load = ser_ready;
                if (ser_ready) state_next = PAYLOAD;
            end
            PAYLOAD: begin
                pl_ready = ser_ready;
                ser_data = pl_data;
                ser_load = pl_valid && ser_ready;
                if (pl_valid && ser_ready) begin
                    checksum_next = checksum_reg ^ pl_data;
                    pl_cnt_next   = pl_cnt_reg + PL_W'(1);
                    if (pl_last || (pl_cnt_reg == PL_LAST_IDX)) state_next = STAR;
                    overlong_next = !pl_last && (pl_cnt_reg == PL_LAST_IDX);
                end
            end
            STAR: begin
                ser_data = CHAR_STAR;
                ser_load = ser_ready;
                if (ser_ready) state_next = CK_HI;
            end
            CK_HI: begin
                ser_data = nibble_to_hex(checksum_reg[7:4]);
                ser_load = ser_ready;
                if (ser_ready) state_next = CK_LO;
            end
            CK_LO: begin
                ser_data = nibble_to_hex(checksum_reg[3:0]);
                ser_load = ser_ready;
                if (ser_ready) state_next = CR;
            end
            CR: begin
                ser_data = CHAR_CR;
                ser_load = ser_ready;
                if (ser_ready) state_next = LF;
            end
            LF: begin
                // Load LF once, then hold here until its stop bit has ended.
                ser_data = CHAR_LF;
                if (!lf_loaded_reg) begin
                    ser_load = ser_ready;
                    if (ser_ready) lf_loaded_next = 1'b1;
                end else if (ser_done) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                lf_loaded_next = 1'b0;
                state_next     = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy     = (state_reg != IDLE);
    assign done     = (state_reg == FINISH);
    assign overlong = overlong_reg;

endmodule

// File: tb/tb_pmtk_cmd_tx.sv
// Bench for pmtk_cmd_tx: a UART receiver monitor decodes the line and checks
// every character against a queue filled from a sentence-level model.
`timescale 1ns/1ps
module tb_pmtk_cmd_tx;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] drv_data;
    logic       drv_last;
    logic       drv_valid;
    logic       drv_sel;
    logic       mon_en;

    logic       pl_valid_a, pl_ready_a, gps_tx_a, busy_a, done_a, overlong_a;
    logic       pl_valid_b, pl_ready_b, gps_tx_b, busy_b, done_b, overlong_b;
    logic [7:0] pl_data_c;
    logic       pl_valid_c, pl_last_c, pl_ready_c, gps_tx_c, busy_c, done_c, overlong_c;

    logic       sel_ready, sel_done, sel_busy, mon_line;

    assign pl_valid_a = drv_valid & ~drv_sel;
    assign pl_valid_b = drv_valid & drv_sel;
    assign sel_ready  = drv_sel ? pl_ready_b : pl_ready_a;
    assign sel_done   = drv_sel ? done_b : done_a;
    assign sel_busy   = drv_sel ? busy_b : busy_a;
    assign mon_line   = !mon_en ? 1'b1 : (drv_sel ? gps_tx_b : gps_tx_a);

    pmtk_cmd_tx #(.CLK_FREQ_HZ(1000), .BAUD_RATE(100), .MAX_PAYLOAD(80)) dut_a (
        .clk(clk), .rst_n(rst_n), .pl_data(drv_data), .pl_valid(pl_valid_a),
        .pl_last(drv_last), .pl_ready(pl_ready_a), .gps_tx(gps_tx_a),
        .busy(busy_a), .done(done_a), .overlong(overlong_a)
    );

    pmtk_cmd_tx #(.CLK_FREQ_HZ(1000), .BAUD_RATE(100), .MAX_PAYLOAD(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .pl_data(drv_data), .pl_valid(pl_valid_b),
        .pl_last(drv_last), .pl_ready(pl_ready_b), .gps_tx(gps_tx_b),
        .busy(busy_b), .done(done_b), .overlong(overlong_b)
    );

    pmtk_cmd_tx dut_c (
        .clk(clk), .rst_n(rst_n), .pl_data(pl_data_c), .pl_valid(pl_valid_c),
        .pl_last(pl_last_c), .pl_ready(pl_ready_c), .gps_tx(gps_tx_c),
        .busy(busy_c), .done(done_c), .overlong(overlong_c)
    );

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    int unsigned last_start_cyc = 0;
    int          done_cnt = 0;
    int          hs_b_cnt = 0;
    int          ovl_a_cnt = 0;
    int          ovl_b_cnt = 0;
    logic [7:0]  exp_q[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sel_done) done_cnt <= done_cnt + 1;
        if (pl_valid_b && pl_ready_b) hs_b_cnt <= hs_b_cnt + 1;
        if (overlong_a) ovl_a_cnt <= ovl_a_cnt + 1;
        if (overlong_b) ovl_b_cnt <= ovl_b_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h cycle=%0d", name, got, exp, cyc);
        end
    endtask

    function automatic bq_t to_q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // Sentence model: '$', payload cut at max_pl bytes, '*', XOR as two hex digits, CR LF.
    task automatic push_model(input bq_t pl, input int max_pl);
        string      hexs = "0123456789ABCDEF";
        logic [7:0] ck = 8'h00;
        int         n;
        n = (pl.size() < max_pl) ? pl.size() : max_pl;
        exp_q.push_back(8'h24);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(pl[i]);
            ck = ck ^ pl[i];
        end
        exp_q.push_back(8'h2A);
        exp_q.push_back(hexs[int'(ck[7:4])]);
        exp_q.push_back(hexs[int'(ck[3:0])]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // UART receiver: samples each bit mid-period and scores the decoded character.
    initial begin : monitor
        logic [7:0]  rx;
        logic [7:0]  e;
        logic        start_bit, stop_bit;
        int unsigned t0;
        forever begin
            @(negedge clk);
            if (mon_line === 1'b0) begin
                t0 = cyc;
                repeat (4) @(negedge clk);
                start_bit = mon_line;
                for (int b = 0; b < 8; b++) begin
                    repeat (10) @(negedge clk);
                    rx[b] = mon_line;
                end
                repeat (10) @(negedge clk);
                stop_bit = mon_line;
                repeat (5) @(negedge clk);
                check("start_bit", {31'd0, start_bit}, 32'd0);
                check("stop_bit", {31'd0, stop_bit}, 32'd1);
                if (rx == 8'h24) last_start_cyc = t0;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_char got=0x%02h exp=none cycle=%0d", rx, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("char", {24'd0, rx}, {24'd0, e});
                end
            end
        end
    end

    task automatic wait_ready(output bit ok);
        int n = 0;
        ok = 1'b1;
        while (sel_ready !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n > 5000) begin
                ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic send_payload(input bq_t pl, input bit use_last, input int gap);
        bit ok;
        for (int i = 0; i < pl.size(); i++) begin
            drv_data  = pl[i];
            drv_last  = use_last && (i == pl.size() - 1);
            drv_valid = 1'b1;
            wait_ready(ok);
            if (!ok) begin
                checks++;
                failures++;
                $display("FAIL handshake_timeout got=no_ready exp=ready byte=%0d", i);
                drv_valid = 1'b0;
                return;
            end
            @(negedge clk);
            drv_valid = 1'b0;
            drv_last  = 1'b0;
            if (gap > 0 && i != pl.size() - 1) begin
                wait_ready(ok);
                repeat (gap) @(negedge clk);
            end
        end
    endtask

    task automatic wait_done(input int base_done, input int exp_span, input string tag);
        int n = 0;
        while (sel_done !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        drv_valid = 1'b0;
        check({tag, "_done_seen"}, {31'd0, sel_done}, 32'd1);
        if (exp_span >= 0) check({tag, "_span"}, cyc - last_start_cyc, exp_span);
        check({tag, "_queue_empty"}, exp_q.size(), 32'd0);
        @(negedge clk);
        check({tag, "_busy_after"}, {31'd0, sel_busy}, 32'd0);
        repeat (3) @(negedge clk);
        check({tag, "_done_pulses"}, done_cnt - base_done, 32'd1);
        $display("sentence %s finished at cycle %0d", tag, cyc);
    endtask

    initial begin : main
        bq_t        pl;
        int         base, base_hs, base_ovl, len, gap, n, bad;
        logic [7:0] ch;

        rst_n = 1'b0; drv_data = 8'h00; drv_last = 1'b0; drv_valid = 1'b0;
        drv_sel = 1'b0; mon_en = 1'b1;
        pl_data_c = 8'h00; pl_valid_c = 1'b0; pl_last_c = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, gps_tx_a}, 32'd1);
        check("rst_ready", {31'd0, pl_ready_a}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_done", {31'd0, done_a}, 32'd0);
        check("rst_overlong", {31'd0, overlong_a}, 32'd0);
        check("rst_tx_c", {31'd0, gps_tx_c}, 32'd1);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Back-to-back sentence with known checksum.
        push_str("$PMTK220,1000*1F");
        base = done_cnt;
        send_payload(to_q("PMTK220,1000"), 1'b1, 0);
        wait_done(base, 1800, "pmtk220");

        // Single-byte payload.
        push_str("$A*41");
        base = done_cnt;
        send_payload(to_q("A"), 1'b1, 0);
        wait_done(base, 700, "single_a");

        // Payload with idle gaps between bytes.
        push_str("$PMTK314,0,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0*29");
        base = done_cnt;
        send_payload(to_q("PMTK314,0,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0"), 1'b1, 37);
        wait_done(base, -1, "pmtk314_gaps");

        // Truncation at MAX_PAYLOAD=4; E is offered but must never be taken.
        drv_sel = 1'b1;
        push_str("$ABCD*04");
        base = done_cnt; base_hs = hs_b_cnt; base_ovl = ovl_b_cnt;
        send_payload(to_q("ABCD"), 1'b0, 0);
        drv_data = 8'h45;
        drv_valid = 1'b1;
        wait_done(base, 1000, "overlong");
        check("overlong_handshakes", hs_b_cnt - base_hs, 32'd4);
        check("overlong_pulses", ovl_b_cnt - base_ovl, 32'd1);
        drv_sel = 1'b0;

        // Random payloads against the model.
        for (int s = 0; s < 4; s++) begin
            pl.delete();
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                do ch = 8'($urandom_range(32, 126)); while (ch == 8'h24 || ch == 8'h2A);
                pl.push_back(ch);
            end
            gap = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 20)) : 0;
            push_model(pl, 80);
            base = done_cnt;
            send_payload(pl, 1'b1, gap);
            wait_done(base, (gap == 0) ? (len + 6) * 100 : -1, "random");
        end

        // Reset in the middle of a sentence.
        mon_en = 1'b0;
        drv_data = 8'h58; drv_last = 1'b0; drv_valid = 1'b1;
        repeat (450) @(negedge clk);
        n = 0;
        while (gps_tx_a !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("line_low_before_reset", {31'd0, gps_tx_a}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("reset_tx_same_cycle", {31'd0, gps_tx_a}, 32'd1);
        check("reset_busy", {31'd0, busy_a}, 32'd0);
        check("reset_ready", {31'd0, pl_ready_a}, 32'd0);
        drv_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (150) begin
            @(negedge clk);
            if (gps_tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
        end
        check("no_resume_after_reset", bad, 32'd0);
        mon_en = 1'b1;
        push_str("$A*41");
        base = done_cnt;
        send_payload(to_q("A"), 1'b1, 0);
        wait_done(base, 700, "after_reset");
        check("overlong_a_never", ovl_a_cnt, 32'd0);

        // Default parameters: '$' = 0x24 gives 3 low bit-times then 1 high.
        pl_data_c = 8'h55; pl_last_c = 1'b1; pl_valid_c = 1'b1;
        n = 0;
        while (gps_tx_c !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("def_start_seen", {31'd0, gps_tx_c}, 32'd0);
        len = 0;
        while (gps_tx_c === 1'b0 && len < 40000) begin
            @(negedge clk);
            len++;
        end
        check("def_low_3_bits", len, 32'd31248);
        len = 0;
        while (gps_tx_c === 1'b1 && len < 20000) begin
            @(negedge clk);
            len++;
        end
        check("def_high_1_bit", len, 32'd10416);
        pl_valid_c = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pmtk_cmd_tx.md
PMTK_CMD_TX -- requirements
Module: pmtk_cmd_tx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ_HZ, default 100000000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 9600, UART bit rate.
REQ-003 The block SHALL have parameter MAX_PAYLOAD, default 80, maximum payload bytes per sentence.
REQ-004 The block SHALL have port clk, input, 1 bit, the only clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port pl_data, input, 8 bits, payload byte (ASCII, between '$' and '*').
REQ-007 The block SHALL have port pl_valid, input, 1 bit, payload byte valid; in IDLE it requests a new sentence.
REQ-008 The block SHALL have port pl_last, input, 1 bit, marks the final payload byte; sampled with pl_data.
REQ-009 The block SHALL have port pl_ready, output, 1 bit, payload byte accepted when pl_valid and pl_ready are both high.
REQ-010 The block SHALL have port gps_tx, output, 1 bit, UART line to the GPS receiver; idle high.
REQ-011 The block SHALL have port busy, output, 1 bit, high from sentence start to LF stop-bit end.
REQ-012 The block SHALL have port done, output, 1 bit, one-cycle pulse at sentence completion.
REQ-013 The block SHALL have port overlong, output, 1 bit, one-cycle pulse when a payload is truncated at MAX_PAYLOAD.

Function
REQ-014 Bit period SHALL be BIT_TICKS = CLK_FREQ_HZ/BAUD_RATE, truncated; this is 10416 cycles at the default parameters.
REQ-015 Each character SHALL be framed 8N1: start 0, data LSB first, stop 1; each bit is held exactly BIT_TICKS cycles.
REQ-016 gps_tx SHALL drive the start bit the cycle after a character is loaded.
REQ-017 Consecutive characters within a sentence SHALL be back-to-back, with no idle between one stop bit and the next start bit.
REQ-018 The FSM SHALL have states IDLE, DOLLAR, PAYLOAD, STAR, CK_HI, CK_LO, CR, LF, FINISH.
REQ-019 In IDLE: pl_ready=0; pl_valid=1 SHALL move the FSM to DOLLAR, clear the checksum, and set busy; the byte is not consumed.
REQ-020 In DOLLAR, '$' (0x24) SHALL be transmitted and the FSM SHALL then enter PAYLOAD.
REQ-021 In PAYLOAD, pl_ready SHALL be high only while the serializer can accept a character.
REQ-022 On each PAYLOAD handshake, pl_data SHALL be transmitted and XORed into the 8-bit checksum.
REQ-023 If pl_valid is low in PAYLOAD, gps_tx SHALL stay at mark (1) with no timeout; the sentence resumes when pl_valid returns.
REQ-024 A handshake with pl_last=1, or the MAX_PAYLOAD-th accepted byte, SHALL end the payload and move the FSM to STAR.
REQ-025 The MAX_PAYLOAD-th byte without pl_last SHALL also pulse overlong for one cycle.
REQ-026 STAR SHALL send '*' (0x2A).
REQ-027 CK_HI and CK_LO SHALL send the checksum high and low nibbles as uppercase ASCII hex ('0'-'9', 'A'-'F').
REQ-028 CR SHALL send 0x0D and LF SHALL send 0x0A.
REQ-029 '$', '*', the checksum characters, CR and LF SHALL NOT enter the checksum.
REQ-030 FINISH SHALL be entered when the LF stop bit ends; in that cycle done=1.
REQ-031 The cycle after FINISH, busy=0 and the FSM SHALL be in IDLE.
REQ-032 A pl_valid in the FINISH cycle SHALL be ignored.
REQ-033 pl_valid held high continuously SHALL start the next sentence on the first IDLE cycle.
REQ-034 A zero-length payload is impossible; the first PAYLOAD handshake is always byte 1.

Reset
REQ-035 rst_n low SHALL asynchronously force: state IDLE, gps_tx=1, pl_ready=0, busy=0, done=0, overlong=0, checksum=0, counters=0.
REQ-036 Reset mid-character SHALL truncate the character immediately; no partial sentence resumes after release.
REQ-037 Reset release SHALL be synchronized before use.

Structure
REQ-038 Package pmtk_tx_pkg SHALL hold: the state enum; character constants '$', '*', CR, LF; the nibble-to-ASCII-hex function.
REQ-039 Sub-module uart_tx_byte SHALL hold the baud counter, bit counter and shift register.
REQ-040 uart_tx_byte SHALL have ports: load, data[7:0], ready, tx, char_done.
REQ-041 pmtk_cmd_tx SHALL hold the framing FSM, checksum register and payload counter.

Verification
REQ-042 The bench SHALL use CLK_FREQ_HZ=1000 and BAUD_RATE=100 (10 cycles/bit, 100 cycles/char) in all scenarios unless stated.
REQ-043 Scenario: stream "PMTK220,1000" -> gps_tx carries "$PMTK220,1000*1F\r\n", 18 chars in exactly 1800 cycles after the first start bit; done pulses once.
REQ-044 Scenario: single byte 'A' with pl_last -> "$A*41\r\n"; checksum chars 0x34 and 0x31; done 700 cycles after the first start bit.
REQ-045 Scenario: "PMTK314,0,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0" with pl_valid gaps of 37 cycles between bytes -> line held at 1 during gaps; sentence ends "*29\r\n".
REQ-046 Scenario: MAX_PAYLOAD=4, 6 bytes "ABCDEF" without pl_last -> "$ABCD*04\r\n"; overlong pulses once; bytes E and F are not accepted while busy.
REQ-047 Scenario: rst_n low at cycle 450 of a sentence -> gps_tx=1 the same cycle.
REQ-048 Scenario: after the REQ-047 reset, a new "A" sentence -> clean "$A*41\r\n".
REQ-049 Scenario: default parameters, one 'U' sentence -> every bit measured at 10416 cycles.
